// File: rtl/stim_seq_pkg.sv
// Shared types and sizes for the 4-input cell stimulus sequencer.
// Holds the controller state encoding and the code/counter widths.
package stim_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_CODES = 16;
    localparam int CODE_W    = 4;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/stim_seq_order.sv
// Step-index to input-code mapping for the stimulus sequencer.
// STIM_SEQ_GRAY_EN selects reflected Gray order; otherwise binary ascending.
module stim_seq_order
    import stim_seq_pkg::*;
(
    input  logic [CODE_W-1:0] step,
    output logic [CODE_W-1:0] code
);

`ifdef STIM_SEQ_GRAY_EN
    // Gray order: exactly one cell input toggles between adjacent steps
    always_comb code = step ^ (step >> 1);
`else
    // Binary order: the code is the step index itself
    always_comb code = step;
`endif

endmodule

// File: rtl/stimulus_sequencer_4b.sv
// Exhaustive 4-input cell characterisation sequencer: FSM, dwell counter,
// compare and result registers. Code order set by STIM_SEQ_GRAY_EN.
module stimulus_sequencer_4b
    import stim_seq_pkg::*;
#(
    parameter int DWELL = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        dut_out,
    output logic        a_stimulus,
    output logic        b_stimulus,
    output logic        c_stimulus,
    output logic        d_stimulus,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_mask,
    output logic [4:0]  fail_count
);

    localparam logic [CNT_W-1:0]  DW_END    = CNT_W'(DWELL - 1);
    localparam logic [CODE_W-1:0] LAST_STEP = CODE_W'(NUM_CODES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W-1:0]   step;
    logic [CODE_W-1:0]   stim;
    logic [CODE_W-1:0]   ord_idx;
    logic [CODE_W-1:0]   ord_code;
    logic                accept;
    logic                at_end;
    logic                last;
    logic                mismatch;

    // Code for the step about to be applied (first step or next step)
    stim_seq_order u_order (
        .step (ord_idx),
        .code (ord_code)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        at_end    = 1'b0;
        last      = 1'b0;
        mismatch  = 1'b0;
        ord_idx   = step + CODE_W'(1);
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = HOLD;
                    accept    = 1'b1;
                    ord_idx   = '0;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == DW_END) begin
                    at_end   = 1'b1;
                    mismatch = (dut_out != expected[stim]);
                    if (step == LAST_STEP) begin
                        last      = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Step/dwell counters, registered stimulus and result registers.
    // The stimulus register holds code(step) during HOLD, so it doubles
    // as the truth-table index for the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            step       <= '0;
            stim       <= '0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_count <= '0;
        end else if (accept) begin
            cnt        <= '0;
            step       <= '0;
            stim       <= ord_code;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_count <= '0;
        end else if (state == HOLD) begin
            if (abort) begin
                stim <= '0;
                pass <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (at_end) begin
                    if (mismatch) begin
                        fail_mask  <= fail_mask | (16'd1 << stim);
                        fail_count <= fail_count + 5'd1;
                    end
                    if (last) begin
                        stim <= '0;
                        pass <= (fail_count == 5'd0) && !mismatch;
                    end else begin
                        step <= step + CODE_W'(1);
                        cnt  <= '0;
                        stim <= ord_code;
                    end
                end
            end
        end else if (state == DONE && abort) begin
            pass <= 1'b0;
        end
    end

    assign a_stimulus = stim[0];
    assign b_stimulus = stim[1];
    assign c_stimulus = stim[2];
    assign d_stimulus = stim[3];
    assign busy       = (state == HOLD);
    assign done       = (state == DONE) && !abort;

endmodule

// File: tb/tb_stimulus_sequencer_4b.sv
// Self-checking bench for stimulus_sequencer_4b (DWELL=4).
// Reference results come from truth-table arithmetic on the modelled cell.
module tb_stimulus_sequencer_4b;

    localparam int DW = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] exp_tt;
    logic        dut_out;
    logic        a_stimulus;
    logic        b_stimulus;
    logic        c_stimulus;
    logic        d_stimulus;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] fail_mask;
    logic [4:0]  fail_count;

    int          checks;
    int          errors;
    int          cell_mode;
    logic [15:0] rand_tt;

    stimulus_sequencer_4b #(.DWELL(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .expected   (exp_tt),
        .dut_out    (dut_out),
        .a_stimulus (a_stimulus),
        .b_stimulus (b_stimulus),
        .c_stimulus (c_stimulus),
        .d_stimulus (d_stimulus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_mask  (fail_mask),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell under test: 0 = ideal NAND4, 1 = stuck-at-1, 2 = random table
    always_comb begin
        dut_out = 1'b0;
        case (cell_mode)
            0:       dut_out = ~&{d_stimulus, c_stimulus, b_stimulus, a_stimulus};
            1:       dut_out = 1'b1;
            default: dut_out = rand_tt[{d_stimulus, c_stimulus, b_stimulus, a_stimulus}];
        endcase
    end

    function automatic logic [3:0] model_code(input int k);
        logic [3:0] kk;
        kk = 4'(k);
`ifdef STIM_SEQ_GRAY_EN
        return kk ^ (kk >> 1);
`else
        return kk;
`endif
    endfunction

    function automatic logic [15:0] cell_table();
        case (cell_mode)
            0:       return 16'h7FFF;
            1:       return 16'hFFFF;
            default: return rand_tt;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] stim_now();
        return {d_stimulus, c_stimulus, b_stimulus, a_stimulus};
    endfunction

    // Full run from IDLE; optionally pulses start again on extra_start cycle
    task automatic run_full(input string tag, input int extra_start);
        logic [15:0] bad;
        logic [3:0]  prev;
        int          done_cyc;
        bad      = cell_table() ^ exp_tt;
        done_cyc = 0;
        prev     = '0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int cyc = 1; cyc <= 16 * DW + 3; cyc++) begin
            if (cyc % DW == 1 && cyc <= 16 * DW) begin
                chk({tag, "_code"}, 32'(stim_now()), 32'(model_code(cyc / DW)));
`ifdef STIM_SEQ_GRAY_EN
                if (cyc > 1)
                    chk({tag, "_onebit"}, $countones(stim_now() ^ prev), 1);
`endif
                prev = stim_now();
            end
            if (cyc == 16 * DW) chk({tag, "_busy_last"}, 32'(busy), 1);
            if (done && done_cyc == 0) begin
                done_cyc = cyc;
                chk({tag, "_busy_in_done"}, 32'(busy), 0);
                chk({tag, "_pass_at_done"}, 32'(pass), 32'(bad == 16'h0));
            end
            if (cyc == 16 * DW + 2) chk({tag, "_done_width"}, 32'(done), 0);
            start = (cyc == extra_start);
            tick();
        end
        start = 1'b0;
        chk({tag, "_done_cyc"}, done_cyc, 16 * DW + 1);
        chk({tag, "_mask"}, 32'(fail_mask), 32'(bad));
        chk({tag, "_count"}, 32'(fail_count), $countones(bad));
        chk({tag, "_pass"}, 32'(pass), 32'(bad == 16'h0));
    endtask

    initial begin
        logic [15:0] partial;
        int          saw_done;
        checks    = 0;
        errors    = 0;
        cell_mode = 0;
        rand_tt   = '0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        exp_tt    = 16'h7FFF;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_mask", 32'(fail_mask), 0);
        chk("rst_count", 32'(fail_count), 0);
        chk("rst_stim", 32'(stim_now()), 0);
        rst = 1'b0;
        tick();

        // Ideal NAND4 with a start pulse while busy
        cell_mode = 0;
        run_full("nand4", 10);

        // Stuck-at-1 cell: only code 15 mismatches
        cell_mode = 1;
        run_full("stuck1", 0);
        chk("stuck1_mask_lit", 32'(fail_mask), 32'h8000);
        tick();
        chk("retain_mask", 32'(fail_mask), 32'h8000);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_stim", 32'(stim_now()), 0);
        tick();
        chk("sa_busy2", 32'(busy), 0);
        chk("sa_mask_kept", 32'(fail_mask), 32'h8000);

        // Randomised cells and expectation tables
        cell_mode = 2;
        for (int r = 0; r < 3; r++) begin
            rand_tt = 16'($urandom);
            exp_tt  = 16'($urandom);
            run_full("rand", 0);
        end

        // Abort during step 5 (cycle T+22)
        rand_tt = 16'($urandom);
        exp_tt  = ~rand_tt ^ 16'($urandom);
        partial = '0;
        for (int k = 0; k < 5; k++)
            partial[model_code(k)] = rand_tt[model_code(k)] ^ exp_tt[model_code(k)];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 22; cyc++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_stim", 32'(stim_now()), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_mask", 32'(fail_mask), 32'(partial));
        chk("abort_count", 32'(fail_count), $countones(partial));
        saw_done = 0;
        for (int cyc = 0; cyc < 16 * DW; cyc++) begin
            if (done) saw_done++;
            tick();
        end
        chk("abort_no_done", saw_done, 0);

        // Reset during step 9, then a fresh run
        rand_tt = 16'($urandom) | 16'h00FF;
        exp_tt  = ~rand_tt;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int cyc = 1; cyc < 38; cyc++) tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_pass", 32'(pass), 0);
        chk("mrst_mask", 32'(fail_mask), 0);
        chk("mrst_count", 32'(fail_count), 0);
        chk("mrst_stim", 32'(stim_now()), 0);
        rst = 1'b0;
        tick();
        cell_mode = 0;
        exp_tt    = 16'h7FFF;
        run_full("after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stimulus_sequencer_4b.md
# stimulus_sequencer_4b

Clocked controller for exhaustive characterization of 4-input combinational cells:
- On `start`, steps through all 16 input codes, holding each for a programmable dwell.
- Samples the cell-under-test output at the end of each dwell and compares it with a 16-entry expected truth table.
- Reports a pass flag, a per-code fail mask and a fail count.
- Replaces free-running, time-delay stimulus with a synthesizable sequencer that sits between the test harness and the cell under test.

## Interface
- `DWELL`, default 20: cycles each code is held, including settle time; legal range 2..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; honoured only in IDLE.
- `abort` input 1: terminate a run; honoured in any state.
- `expected` input 16: expected cell output; bit *n* is the expected output for input code *n*.
- `dut_out` input 1: output of the cell under test.
- `a_stimulus`, `b_stimulus`, `c_stimulus`, `d_stimulus` output 1 each: cell inputs; `a` is code bit 0 and `d` is code bit 3.
- `busy` output 1: high while codes are being applied.
- `done` output 1: one-cycle pulse at normal completion.
- `pass` output 1: 1 when the last completed run had zero mismatches.
- `fail_mask` output 16: bit *n* set when code *n* mismatched.
- `fail_count` output 5: number of mismatches, 0..16.

## Operation
- **States:** IDLE, HOLD, DONE.
- **IDLE:**
  - Stimulus outputs are 0 and `busy` is 0.
  - `start`=1 and `abort`=0 → HOLD.
  - Entering HOLD: step index = 0, dwell counter = 0, `fail_mask` = 0, `fail_count` = 0, `pass` = 0.
- **HOLD:**
  - Stimulus outputs drive `code(step)`.
  - The dwell counter increments every cycle.
  - On the cycle the counter equals DWELL-1, compare `dut_out` with `expected[code(step)]`.
  - On mismatch, set `fail_mask[code(step)]` and increment `fail_count`.
  - If step < 15: increment step, clear the counter, stay in HOLD.
  - If step = 15: go to DONE.
- **DONE:**
  - `done` = 1 for exactly this cycle.
  - `pass` is loaded with (final `fail_count` == 0), including the mismatch from the last compare.
  - Stimulus outputs return to 0.
  - Next state is IDLE unconditionally.
- **Result retention:** `fail_mask`, `fail_count` and `pass` hold their values until the next accepted `start` or `rst`.
- **Abort:**
  - From HOLD or DONE, go to IDLE next cycle with stimulus outputs at 0 and no `done` pulse.
  - `pass` = 0.
  - `fail_mask` and `fail_count` keep their partial values.
  - A compare scheduled in the same cycle as `abort` is discarded.
- **Ignored inputs:**
  - `start` in HOLD or DONE is ignored.
  - `start` and `abort` together in IDLE: abort wins and the block stays in IDLE.
- **Reset values:** `rst` in any state → IDLE next cycle. All outputs are 0, counters are 0, `pass` = 0.
- **Widths:**
  - The dwell counter is 8 bits.
  - The step index is 4 bits and never wraps, because the last step exits HOLD.
  - `fail_count` saturation is not needed, since the maximum value is 16.

## Timing
- `start` is sampled at edge T.
- Code for step *k* is stable on cycles T+1+k·DWELL through T+(k+1)·DWELL.
- The compare for step *k* occurs on cycle T+(k+1)·DWELL.
- `busy` = 1 on cycles T+1 … T+16·DWELL.
- `done` = 1 on cycle T+16·DWELL+1, with `pass` valid that same cycle.
- `busy` is 0 in DONE.
- Earliest next accepted `start` is sampled on cycle T+16·DWELL+2.
- Stimulus outputs change only on step boundaries and are registered (glitch-free).

## Configuration
- **`STIM_SEQ_GRAY_EN` defined:** `code(k)` = k ^ (k>>1), giving the order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Exactly one input toggles per step, for single-input transition characterization.
- **`STIM_SEQ_GRAY_EN` undefined:** `code(k)` = k, binary ascending 0..15.
- In both modes, `fail_mask` and `expected` are indexed by code value, not by step.

## Structure
- **Package `stim_seq_pkg`:**
  - state enum (IDLE, HOLD, DONE);
  - `NUM_CODES` = 16;
  - `CODE_W` = 4;
  - `CNT_W` = 8.
- **Sub-module `stim_seq_order`:** purely combinational step→code mapping. It is the only place `STIM_SEQ_GRAY_EN` is tested.
- The top holds the FSM, counters, compare logic and result registers.

## Test plan
- **Ideal NAND4:** DWELL=4, `expected`=16'h7FFF, bench models a NAND4 → `done` at T+65, `pass`=1, `fail_mask`=0, `fail_count`=0.
- **Stuck-at-1 cell:** DWELL=4, `expected`=16'h7FFF, `dut_out` tied 1 → `pass`=0, `fail_mask`=16'h8000, `fail_count`=1.
- **Abort mid-run:** binary mode, assert `abort` on cycle T+22 (step 5) → next cycle stimulus is 0 and `busy` is 0; `done` never pulses; `fail_mask` is unchanged from before the abort; `pass`=0.
- **Start while busy:** pulse `start` at T+10 → ignored, `done` still at T+65. Also assert `start` and `abort` together in IDLE → stays IDLE.
- **Gray order:** with `STIM_SEQ_GRAY_EN`, record {d,c,b,a} per step → 0,1,3,2,6,…,8, one bit change per step. The NAND4 run still gives `pass`=1.
- **Reset mid-run:** assert `rst` at step 9 → all outputs 0 next cycle. A new `start` then completes normally with fresh results.
